// File: rtl/led_pwm_pkg.sv
// Shared constants and types for the LED PWM slot: register map and duty storage types.
package led_pwm_pkg;
  localparam int         DW_DEF     = 8;
  localparam int         MAX_LED    = 16;
  localparam logic [4:0] ADDR_CTRL  = 5'd0;
  localparam logic [4:0] ADDR_DVSR  = 5'd1;
  localparam logic [4:0] ADDR_DUTY0 = 5'd2;

  // Duty values carry one extra bit so 2^DW can express "always on".
  typedef logic [DW_DEF:0]       duty_t;
  typedef duty_t [MAX_LED-1:0]   duty_arr_t;
endpackage

// File: rtl/led_pwm_tick_gen.sv
// Prescaler: free-running counter that pulses tick once every DVSR+1 cycles while enabled.
module tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] dvsr,
  output logic        tick
);
  logic [15:0] cnt_q, cnt_d;

  // >= rather than == so a DVSR shrunk below the running count wraps right away.
  assign tick = en && (cnt_q >= dvsr);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!en || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_pwm.sv
// Multi-channel LED PWM with bus-mapped control, prescaler and period-aligned duty updates.
module led_pwm
  import led_pwm_pkg::*;
#(
  parameter int N_LED = 4,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             read,
  input  logic             write,
  input  logic [4:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic [N_LED-1:0] led
);
  logic                      en_q;
  logic [15:0]               dvsr_q;
  logic [DW-1:0]             pwm_q;
  logic [N_LED-1:0][DW:0]    shadow_q, active_q;
  logic [N_LED-1:0]          led_q;
  logic                      tick, wrap, wr;
  logic [31:0]               rd_val;
  logic                      unused_bits;

  assign wr   = cs && write;
  assign wrap = tick && (pwm_q == '1);

  tick_gen u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en_q),
    .dvsr (dvsr_q),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q     <= 1'b0;
      dvsr_q   <= '0;
      pwm_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      led_q    <= '0;
    end else begin
      if (wr && addr == ADDR_CTRL) en_q   <= wr_data[0];
      if (wr && addr == ADDR_DVSR) dvsr_q <= wr_data[15:0];
      for (int i = 0; i < N_LED; i++)
        if (wr && addr == ADDR_DUTY0 + 5'(i)) shadow_q[i] <= wr_data[DW:0];

      if (!en_q)     pwm_q <= '0;
      else if (tick) pwm_q <= pwm_q + DW'(1);

      // Shadow write on the wrap edge lands next period: NBA picks up the old shadow.
      if (!en_q || wrap) active_q <= shadow_q;

      for (int i = 0; i < N_LED; i++)
        led_q[i] <= en_q && ({1'b0, pwm_q} < active_q[i]);
    end
  end

  always_comb begin
    rd_val = '0;
    if (addr == ADDR_CTRL) rd_val = {31'b0, en_q};
    if (addr == ADDR_DVSR) rd_val = {16'b0, dvsr_q};
    for (int i = 0; i < N_LED; i++)
      if (addr == ADDR_DUTY0 + 5'(i)) rd_val = 32'(shadow_q[i]);
  end

  // Reads are side-effect free, so the strobe itself is not needed.
  assign unused_bits = ^{read, wr_data[31:16]};

  assign rd_data = cs ? rd_val : 'z;
  assign led     = led_q;
endmodule

// File: tb/tb_led_pwm.sv
// Self-checking bench for led_pwm: per-cycle reference model plus hand-computed period counts.
module tb_led_pwm;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int PER = 1 << DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]    addr = '0;
  logic [31:0]   wr_data = '0;
  wire  [31:0]   rd_data;
  wire  [N-1:0]  led;
  pullup pu_rd (rd_data);

  led_pwm #(.N_LED(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .led(led)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, chk_cnt = 0;
  bit run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tick every dvsr+1 cycles, pwm position advances per tick,
  // duties latched at period boundaries, led shows the previous cycle's decision.
  bit           m_en = 0;
  int           m_dvsr = 0, m_pre = 0, m_pwm = 0;
  int           m_shadow[N], m_active[N];
  logic [N-1:0] m_led = '0, m_nl;
  bit           m_tick;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return {31'b0, m_en};
    if (a == 1) return 32'(m_dvsr);
    if (a >= 2 && a < 2 + N) return 32'(m_shadow[a - 2]);
    return 32'h0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_en = 0; m_dvsr = 0; m_pre = 0; m_pwm = 0; m_led = '0;
      for (int i = 0; i < N; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++) m_nl[i] = m_en && (m_pwm < m_active[i]);
      m_tick = m_en && (m_pre >= m_dvsr);
      if (!m_en) begin
        m_pre = 0; m_pwm = 0;
        for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
      end else if (m_tick) begin
        if (m_pwm == PER - 1) for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
        m_pwm = (m_pwm + 1) % PER;
        m_pre = 0;
      end else m_pre++;
      if (cs && write) begin
        if (addr == 0) m_en = wr_data[0];
        else if (addr == 1) m_dvsr = int'(wr_data[15:0]);
        else if (addr >= 2 && addr < 2 + N) m_shadow[addr - 2] = int'(wr_data[DW:0]);
      end
      m_led = m_nl;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("led_model", 32'(led), 32'(m_led));
      check("rd_model", rd_data, cs ? m_read(addr) : 32'hFFFF_FFFF);
    end
  end

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cs = 1; write = 1; read = 0; addr = a; wr_data = d;
    @(posedge clk); #1;
    cs = 0; write = 0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    cs = 1; read = 1; write = 0; addr = a;
    #2 d = rd_data;
    cs = 0; read = 0;
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cs = 0; write = 0; read = 0;
      case ($urandom_range(0, 15))
        0, 1: begin
          cs = 1; write = 1; addr = 5'($urandom_range(0, 7));
          if (addr == 0)      wr_data = ($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 3) != 0);
          else if (addr == 1) wr_data = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 5));
          else                wr_data = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 300));
        end
        2, 3, 4: begin cs = 1; read = 1; addr = 5'($urandom_range(0, 31)); end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    cs = 0; write = 0; read = 0;
  endtask

  logic [31:0] rv;
  int c0a, c0b, c0c, c1, c2;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    run = 1;

    // reset state
    bus_rd(0, rv); check("rst_ctrl", rv, 32'h0);
    bus_rd(1, rv); check("rst_dvsr", rv, 32'h0);
    bus_rd(2, rv); check("rst_duty0", rv, 32'h0);

    // bus behaviour
    bus_wr(1, 32'hABCD_1234);
    bus_rd(1, rv); check("dvsr_rd", rv, 32'h0000_1234);
    bus_wr(7, 32'hFFFF_FFFF);
    bus_rd(1, rv); check("unmapped_wr_dvsr", rv, 32'h0000_1234);
    bus_rd(0, rv); check("unmapped_wr_ctrl", rv, 32'h0);
    bus_rd(7, rv); check("unmapped_rd", rv, 32'h0);
    #1 check("cs0_highz", rd_data, 32'hFFFF_FFFF);

    // duty, extremes and glitch-free update (DVSR=0)
    bus_wr(1, 0);
    bus_wr(2, 64); bus_wr(3, 0); bus_wr(4, 256); bus_wr(5, 32'($urandom_range(0, 256)));
    bus_wr(0, 1);
    c0a = 0; c0b = 0; c0c = 0; c1 = 0; c2 = 0;
    for (int k = 1; k <= 3 * PER; k++) begin
      @(posedge clk); #1;
      if (k <= PER) c0a += int'(led[0]);
      else if (k <= 2 * PER) c0b += int'(led[0]);
      else c0c += int'(led[0]);
      c1 += int'(led[1]); c2 += int'(led[2]);
      cs = 0; write = 0;
      if (k == 100) begin cs = 1; write = 1; addr = 2; wr_data = 192; end
    end
    check("duty64_period1", 32'(c0a), 32'd64);
    check("duty192_period2", 32'(c0b), 32'd192);
    check("duty192_period3", 32'(c0c), 32'd192);
    check("duty0_const", 32'(c1), 32'd0);
    check("duty256_const", 32'(c2), 32'd768);

    // prescale: DVSR=3 stretches each PWM step to 4 cycles
    bus_wr(0, 0); bus_wr(2, 1); bus_wr(1, 3); bus_wr(0, 1);
    c0a = 0;
    for (int k = 1; k <= 4 * PER; k++) begin @(posedge clk); #1; c0a += int'(led[0]); end
    check("prescale_high", 32'(c0a), 32'd4);

    rand_cycles(3000);

    // asynchronous reset mid-operation
    bus_wr(2, 200); bus_wr(1, 0); bus_wr(0, 1);
    repeat (37) @(posedge clk);
    #1 rst = 0;
    #1 check("async_rst_led", 32'(led), 32'h0);
    cs = 1; read = 1; addr = 0; #1 check("async_rst_ctrl", rd_data, 32'h0);
    addr = 1; #1 check("async_rst_dvsr", rd_data, 32'h0);
    addr = 2; #1 check("async_rst_duty0", rd_data, 32'h0);
    cs = 0; read = 0;
    @(posedge clk); #1 rst = 1;
    c0a = 0;
    for (int k = 0; k < 300; k++) begin @(posedge clk); #1; c0a += int'(led != '0); end
    check("no_resume_after_rst", 32'(c0a), 32'd0);

    rand_cycles(1500);
    run = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
